// File: rtl/counter_spi_tx_if.sv
// counter_spi_tx_if
//   Bundles the counter capture request and the SPI pins of counter_spi_tx.
//   count : counter value to send (COUNT_W bits)
//   start : frame request, sampled every cycle
//   sclk  : SPI clock, idles low
//   mosi  : SPI data out, MSB first
//   cs_n  : SPI chip select, active low
//   busy  : transfer in progress
//   done  : one-cycle end-of-frame pulse
//   master modport: the transmitter side; slave modport: the requester/observer side.
interface counter_spi_tx_if #(
    parameter int COUNT_W = 14
);
    logic [COUNT_W-1:0] count;
    logic               start;
    logic               sclk;
    logic               mosi;
    logic               cs_n;
    logic               busy;
    logic               done;

    modport master (
        input  count, start,
        output sclk, mosi, cs_n, busy, done
    );

    modport slave (
        output count, start,
        input  sclk, mosi, cs_n, busy, done
    );
endinterface

// File: rtl/counter_spi_tx.sv
// counter_spi_tx
//   SPI mode-0 master transmitter. Captures the counter value, zero-extends
//   it to a 16-bit frame and shifts it out MSB first under one cs_n assertion.
//   Ports:
//     clk  : system clock, rising edge
//     rst  : synchronous active-high reset, aborts any frame
//     bus  : counter_spi_tx_if.master (count, start in; sclk, mosi, cs_n,
//            busy, done out)
//   Parameters:
//     COUNT_W : width of count (<= 16)
//     CLK_DIV : clk cycles per SCLK half-period (>= 1)
//   Optional feature macro SPI_SEND_ON_CHANGE_EN: when defined, any difference
//   between count and the last captured value triggers a frame while idle.
module counter_spi_tx #(
    parameter int COUNT_W = 14,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    counter_spi_tx_if.master bus
);
    localparam int DIV_W = $clog2(CLK_DIV + 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        HOLD,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [15:0]       shift_reg;
    logic [3:0]        bit_cnt;
    logic [DIV_W-1:0]  div_cnt;

    logic div_last;
    logic change;
    logic trigger;
    logic load;
    logic shift;

    logic sclk;
    logic mosi;
    logic cs_n;
    logic busy;
    logic done;

    assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));

`ifdef SPI_SEND_ON_CHANGE_EN
    logic [COUNT_W-1:0] last_sent;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_sent <= '0;
        end else if (load) begin
            last_sent <= bus.count;
        end
    end

    assign change = (bus.count != last_sent);
`else
    assign change = 1'b0;
`endif

    assign trigger = bus.start | change;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                shift_reg <= 16'(bus.count[COUNT_W-1:0]);
                bit_cnt   <= '0;
            end else if (shift) begin
                shift_reg <= {shift_reg[14:0], 1'b0};
                bit_cnt   <= bit_cnt + 4'd1;
            end
            // Phase timer restarts on every state change, so each timed
            // state lasts exactly CLK_DIV cycles.
            if (state_next != state) begin
                div_cnt <= '0;
            end else if (busy) begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        sclk       = 1'b0;
        mosi       = 1'b0;
        cs_n       = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    load       = 1'b1;
                    state_next = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                cs_n = 1'b0;
                busy = 1'b1;
                mosi = shift_reg[15];
                if (div_last) state_next = SHIFT_HI;
            end
            SHIFT_HI: begin
                cs_n = 1'b0;
                busy = 1'b1;
                sclk = 1'b1;
                mosi = shift_reg[15];
                if (div_last) begin
                    if (bit_cnt == 4'd15) begin
                        state_next = HOLD;
                    end else begin
                        shift      = 1'b1;
                        state_next = SHIFT_LO;
                    end
                end
            end
            HOLD: begin
                cs_n = 1'b0;
                busy = 1'b1;
                mosi = shift_reg[15];
                if (div_last) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                // A trigger here starts the next frame straight away, leaving
                // this single cycle as the cs_n-high gap.
                if (trigger) begin
                    load       = 1'b1;
                    state_next = SHIFT_LO;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.sclk = sclk;
    assign bus.mosi = mosi;
    assign bus.cs_n = cs_n;
    assign bus.busy = busy;
    assign bus.done = done;
endmodule

// File: tb/tb_counter_spi_tx.sv
// tb_counter_spi_tx
//   Directed/randomized bench for counter_spi_tx at CLK_DIV=4. Expected pin
//   behaviour is computed from the frame timing arithmetic (cycle k after the
//   trigger edge) and a bench-side slave that shifts in mosi on each sclk rise.
module tb_counter_spi_tx;
    localparam int D = 4;
    localparam int FRAME = 33 * D;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    counter_spi_tx_if #(.COUNT_W(14)) bus ();

    counter_spi_tx #(.COUNT_W(14), .CLK_DIV(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one frame from the trigger edge through the done cycle. Caller is
    // at a negedge; count/start set here are seen by the next rising edge.
    task automatic frame(input string tag, input logic [13:0] val, input bit use_start,
                         input bit hold, input int chg_k, input logic [13:0] chg_val,
                         input int start_k);
        logic [15:0] w;
        logic [15:0] rx;
        logic        prev_sclk;
        logic        e_sclk, e_mosi, e_cs, e_busy, e_done, chk_mosi;
        int          rises, busy_n, done_n, wave_err, ph;
        w = 16'(val);
        bus.count = val;
        if (use_start) bus.start = 1'b1;
        rx = '0; prev_sclk = 1'b0;
        rises = 0; busy_n = 0; done_n = 0; wave_err = 0;
        for (int k = 1; k <= FRAME + 1; k++) begin
            @(negedge clk);
            if (k == 1 && !hold) bus.start = 1'b0;
            if (bus.sclk === 1'b1 && prev_sclk === 1'b0) begin
                rises++;
                rx = {rx[14:0], bus.mosi};
            end
            prev_sclk = bus.sclk;
            if (bus.busy === 1'b1) busy_n++;
            if (bus.done === 1'b1) done_n++;
            if (k <= FRAME) begin
                e_busy = 1'b1; e_cs = 1'b0; e_done = 1'b0;
                if (k <= 32 * D) begin
                    ph = (k - 1) / D;
                    e_sclk = ph[0];
                    e_mosi = w[15 - ph / 2];
                    chk_mosi = 1'b1;
                end else begin
                    e_sclk = 1'b0; e_mosi = 1'b0; chk_mosi = 1'b0;
                end
            end else begin
                e_busy = 1'b0; e_cs = 1'b1; e_done = 1'b1;
                e_sclk = 1'b0; e_mosi = 1'b0; chk_mosi = 1'b1;
            end
            if (bus.busy !== e_busy || bus.cs_n !== e_cs || bus.done !== e_done ||
                bus.sclk !== e_sclk || (chk_mosi && bus.mosi !== e_mosi))
                wave_err++;
            if (k == chg_k) bus.count = chg_val;
            if (k == start_k) bus.start = 1'b1;
            if (start_k > 0 && k == start_k + 1) bus.start = 1'b0;
        end
        check({tag, " word"}, 32'(rx), 32'(w));
        check({tag, " sclk_rises"}, rises, 16);
        check({tag, " busy_cycles"}, busy_n, FRAME);
        check({tag, " done_pulses"}, done_n, 1);
        check({tag, " waveform_errors"}, wave_err, 0);
    endtask

    // No frame activity expected for n cycles.
    task automatic idle_check(input string tag, input int n);
        int act;
        act = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.cs_n !== 1'b1 || bus.sclk !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
                act++;
        end
        check({tag, " idle_activity"}, act, 0);
    endtask

    initial begin
        logic [13:0] a;
        logic [13:0] b;
        int          act;
        total = 0;
        bad   = 0;

        // Reset defaults
        rst = 1'b1; bus.start = 1'b0; bus.count = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst sclk", 32'(bus.sclk), 32'd0);
        check("rst cs_n", 32'(bus.cs_n), 32'd1);
        check("rst mosi", 32'(bus.mosi), 32'd0);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        idle_check("post_rst", 10);

        // Single frames: test-plan value, boundaries, random
        frame("f1234", 14'd1234, 1'b1, 1'b0, -1, '0, -1);
        idle_check("f1234", 20);
        frame("fzero", 14'd0, 1'b1, 1'b0, -1, '0, -1);
        idle_check("fzero", 20);
        frame("fmax", 14'h3FFF, 1'b1, 1'b0, -1, '0, -1);
        idle_check("fmax", 20);
        for (int i = 0; i < 4; i++) begin
            a = 14'($urandom_range(0, 16383));
            frame("frand", a, 1'b1, 1'b0, -1, '0, -1);
            idle_check("frand", 10);
        end

`ifndef SPI_SEND_ON_CHANGE_EN
        // Capture value held; start while busy ignored
        frame("capture", 14'd5, 1'b1, 1'b0, 20, 14'd9999, 40);
        idle_check("no_queue", 150);
        // Count changes alone never start a frame
        bus.count = 14'd77;
        idle_check("no_auto", 150);
`endif

        // Back-to-back with start held through both frames
        a = 14'($urandom_range(0, 16383));
        b = 14'($urandom_range(0, 16383));
        frame("b2b1", a, 1'b1, 1'b1, 50, b, -1);
        frame("b2b2", b, 1'b1, 1'b0, -1, '0, -1);
        idle_check("b2b", 20);

        // Reset at bit 7
        a = 14'($urandom_range(0, 16383));
        bus.count = a;
        bus.start = 1'b1;
        for (int k = 1; k <= 14 * D + 1; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        check("pre_rst busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        bus.count = '0;
        @(negedge clk);
        check("midrst cs_n", 32'(bus.cs_n), 32'd1);
        check("midrst sclk", 32'(bus.sclk), 32'd0);
        check("midrst busy", 32'(bus.busy), 32'd0);
        check("midrst done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        act = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0) act++;
        end
        check("midrst no_done", act, 0);

`ifdef SPI_SEND_ON_CHANGE_EN
        // Change-driven frames, start held low
        frame("chg1", 14'd1, 1'b0, 1'b0, -1, '0, -1);
        idle_check("chg1", 20);
        frame("chg2", 14'd2, 1'b0, 1'b0, -1, '0, -1);
        idle_check("chg_const", 300);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
